ex_stage_ctrl: RTL and testbench
================================

Name: ex_stage_ctrl

Overview:
- Execute-stage controller for the pipeline's combinational ALU.
- Accepts decoded instructions from ID over a valid/ready handshake and holds them in the EX pipeline register.
- Drives the ALU's operand, opcode and branch/jump inputs, then registers non-control results into the EX/MEM output slot under backpressure.
- Resolves branches and jumps, and issues a one-cycle registered redirect plus flush to fetch/decode.

Parameters:
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  EX accepts this cycle.
- id_pc  in  32  instruction PC.
- id_op1  in  32  operand 1.
- id_op2  in  32  operand 2.
- id_aluop  in  3  ALU opcode (1 add, 2 sub, 3 and, 4 or, 5 sltu, 6 eq, 7 slt).
- id_branch  in  1  conditional branch.
- id_bne  in  1  invert branch sense (taken when not equal).
- id_jump  in  1  unconditional jump.
- id_addr  in  26  offset/jump-index field.
- id_rd  in  RD_W  destination register.
- id_wen  in  1  writeback enable.
- alu_op  out  3  to ALU aluOp.
- alu_a  out  32  to ALU operand1.
- alu_b  out  32  to ALU operand2.
- alu_pc  out  32  to ALU pc.
- alu_addr  out  26  to ALU addrInfo.
- alu_branch  out  1  to ALU branch.
- alu_jump  out  1  to ALU jump.
- alu_result  in  32  from ALU aluResult.
- alu_target  in  32  from ALU targetAddr.
- ex_valid  out  1  output slot holds a result.
- ex_ready  in  1  MEM accepts the slot.
- ex_result  out  32  registered result.
- ex_rd  out  RD_W  registered destination.
- ex_wen  out  1  registered write enable.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  redirect target.
- flush  out  1  kill younger instructions in IF/ID; coincident with redirect_valid.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
  - Reset (rst_n=0 at an edge) clears state to EMPTY and the EX register valid bit.
  - Reset values: ex_valid=0, ex_result=0, ex_rd=0, ex_wen=0, redirect_valid=0, redirect_pc=0, flush=0.
  - id_ready is forced 0 whenever rst_n=0.
  - Reset mid-operation, including during REDIRECT, discards all in-flight work; no redirect pulse is emitted afterwards.
- ALU drive: ALU ports are driven directly from the EX register.
  - When EX is empty, drive alu_op=0, alu_branch=0, alu_jump=0.
  - If id_branch and id_jump are both set, the instruction is treated as a branch (branch has priority).
- State machine, 3 states:
  - EMPTY: EX register invalid; id_ready=1. Accept (id_valid&&id_ready) → BUSY.
  - BUSY: EX register holds an instruction. Let slot_free = !ex_valid || ex_ready.
    - Non-control instruction: id_ready = slot_free.
      - If slot_free at the edge: load ex_result=alu_result, ex_rd, ex_wen, and set ex_valid=1.
      - At the same edge, if id_valid: reload EX and stay BUSY; else → EMPTY.
      - If !slot_free: hold EX and stay BUSY.
    - Control instruction (branch or jump): id_ready=0 (one mandatory bubble). Control instructions never occupy the output slot.
      - taken = jump || (branch && (alu_result[0] ^ bne)).
      - Taken: latch redirect_pc=alu_target; → REDIRECT.
      - Not taken: → EMPTY.
  - REDIRECT: redirect_valid=1 and flush=1 for exactly this cycle; id_ready=0; → EMPTY.
- Opcode 0 on a non-control instruction is illegal: ex_result is forced to 0 and ex_wen is still passed through.
- Output slot: ex_valid stays high and ex_result/ex_rd/ex_wen stay stable until a cycle with ex_ready=1. When ex_valid=0, ex_ready is ignored.
- Latency:
  - ALU instruction accepted at edge E0 → ex_valid visible in the cycle after E1, assuming the slot is free.
  - Taken control instruction accepted at E0 → redirect in the cycle after E1; id_ready=1 again after E2.
  - Sustained throughput for back-to-back ALU instructions with ex_ready=1: one per cycle.
- Width rules: all datapaths are 32-bit; no arithmetic in this block beyond the taken XOR.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with id_valid=1 → id_ready=0 and all outputs 0 throughout; first cycle after release id_ready=1 and nothing was accepted.
2. ADD: op1=5, op2=7, aluop=1, rd=3, wen=1, ex_ready=1 → ex_valid=1 two edges after accept with ex_result=12, ex_rd=3; then SUB 7−5 back-to-back gives ex_result=2 on the next cycle.
3. Backpressure: ex_ready=0 and three ALU instructions offered (AND 0xF0&0x3C, OR 0xF0|0x0F, ...) → first held in slot (0x30), second in EX, id_ready=0; after ex_ready=1, results 0x30 then 0xFF emerge in order with none lost or duplicated.
4. Taken BEQ: op1=op2=9, aluop=6, pc=0x100, addr=0x0004 → id_ready=0 during EX and REDIRECT; redirect_valid=flush=1 for one cycle with redirect_pc=0x110; ex_valid stays 0.
5. Not-taken cases: BEQ with 9 vs 8, and BNE with 9 vs 9 → no redirect; id_ready=1 the cycle after EX.
6. Jump and reset: jump with pc=0xA0000000, addr=0x40 → redirect_pc=0xA0000100. Repeat with rst_n=0 asserted in the EX cycle → no redirect pulse, state EMPTY.

Source files
------------

// File: rtl/ex_stage_ctrl.sv
// Execute-stage controller: holds one decoded instruction in the EX register,
// feeds the external combinational ALU, registers non-control results into a
// backpressured EX/MEM slot, and turns taken branches/jumps into a one-cycle
// redirect + flush pulse.
module ex_stage_ctrl #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     id_pc,
    input  logic [31:0]     id_op1,
    input  logic [31:0]     id_op2,
    input  logic [2:0]      id_aluop,
    input  logic            id_branch,
    input  logic            id_bne,
    input  logic            id_jump,
    input  logic [25:0]     id_addr,
    input  logic [RD_W-1:0] id_rd,
    input  logic            id_wen,
    output logic [2:0]      alu_op,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [31:0]     alu_pc,
    output logic [25:0]     alu_addr,
    output logic            alu_branch,
    output logic            alu_jump,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     alu_target,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_result,
    output logic [RD_W-1:0] ex_rd,
    output logic            ex_wen,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic            flush
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        BUSY     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state_reg;

    // EX pipeline register (valid bit is implied by state_reg == BUSY)
    logic [31:0]     pc_reg;
    logic [31:0]     op1_reg;
    logic [31:0]     op2_reg;
    logic [2:0]      aluop_reg;
    logic            branch_reg;
    logic            bne_reg;
    logic            jump_reg;
    logic [25:0]     addr_reg;
    logic [RD_W-1:0] rd_reg;
    logic            wen_reg;

    // EX/MEM output slot and redirect registers
    logic            ex_valid_reg;
    logic [31:0]     ex_result_reg;
    logic [RD_W-1:0] ex_rd_reg;
    logic            ex_wen_reg;
    logic            redirect_valid_reg;
    logic [31:0]     redirect_pc_reg;

    logic busy;
    logic is_ctrl;
    logic slot_free;
    logic taken;
    logic accept;

    assign busy      = (state_reg == BUSY);
    assign is_ctrl   = branch_reg | jump_reg;
    assign slot_free = !ex_valid_reg || ex_ready;
    // Branch sense comes from bit 0 of the ALU compare result, optionally inverted.
    assign taken     = jump_reg || (branch_reg && (alu_result[0] ^ bne_reg));
    assign accept    = id_valid && id_ready;

    // Accept when empty, or when a non-control instruction can retire into the slot.
    always_comb begin
        id_ready = 1'b0;
        if (rst_n) begin
            case (state_reg)
                EMPTY:   id_ready = 1'b1;
                BUSY:    id_ready = !is_ctrl && slot_free;
                default: id_ready = 1'b0;
            endcase
        end
    end

    // ALU inputs come straight from the EX register; control lines are gated when empty.
    always_comb begin
        alu_op     = busy ? aluop_reg : 3'd0;
        alu_branch = busy & branch_reg;
        alu_jump   = busy & jump_reg;
        alu_a      = op1_reg;
        alu_b      = op2_reg;
        alu_pc     = pc_reg;
        alu_addr   = addr_reg;
    end

    // Load the EX register on every accepted instruction; branch wins over jump.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg     <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            aluop_reg  <= '0;
            branch_reg <= 1'b0;
            bne_reg    <= 1'b0;
            jump_reg   <= 1'b0;
            addr_reg   <= '0;
            rd_reg     <= '0;
            wen_reg    <= 1'b0;
        end else if (accept) begin
            pc_reg     <= id_pc;
            op1_reg    <= id_op1;
            op2_reg    <= id_op2;
            aluop_reg  <= id_aluop;
            branch_reg <= id_branch;
            bne_reg    <= id_bne && id_branch;
            jump_reg   <= id_jump && !id_branch;
            addr_reg   <= id_addr;
            rd_reg     <= id_rd;
            wen_reg    <= id_wen;
        end
    end

    // Control FSM with registered output slot and redirect pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= EMPTY;
            ex_valid_reg       <= 1'b0;
            ex_result_reg      <= '0;
            ex_rd_reg          <= '0;
            ex_wen_reg         <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            redirect_valid_reg <= 1'b0;
            // Slot drains whenever MEM takes it; a new load below overrides this.
            if (ex_valid_reg && ex_ready) begin
                ex_valid_reg <= 1'b0;
            end
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (is_ctrl) begin
                        if (taken) begin
                            redirect_valid_reg <= 1'b1;
                            redirect_pc_reg    <= alu_target;
                            state_reg          <= REDIRECT;
                        end else begin
                            state_reg <= EMPTY;
                        end
                    end else if (slot_free) begin
                        ex_valid_reg  <= 1'b1;
                        // Opcode 0 is illegal: zero the result but keep the write enable.
                        ex_result_reg <= (aluop_reg == 3'd0) ? 32'd0 : alu_result;
                        ex_rd_reg     <= rd_reg;
                        ex_wen_reg    <= wen_reg;
                        state_reg     <= accept ? BUSY : EMPTY;
                    end
                end
                REDIRECT: begin
                    state_reg <= EMPTY;
                end
                default: begin
                    state_reg <= EMPTY;
                end
            endcase
        end
    end

    assign ex_valid       = ex_valid_reg;
    assign ex_result      = ex_result_reg;
    assign ex_rd          = ex_rd_reg;
    assign ex_wen         = ex_wen_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign flush          = redirect_valid_reg;

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed bench for ex_stage_ctrl with a small behavioural ALU attached.
module tb_ex_stage_ctrl;

    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_pc;
    logic [31:0]     id_op1;
    logic [31:0]     id_op2;
    logic [2:0]      id_aluop;
    logic            id_branch;
    logic            id_bne;
    logic            id_jump;
    logic [25:0]     id_addr;
    logic [RD_W-1:0] id_rd;
    logic            id_wen;
    logic [2:0]      alu_op;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [31:0]     alu_pc;
    logic [25:0]     alu_addr;
    logic            alu_branch;
    logic            alu_jump;
    logic [31:0]     alu_result;
    logic [31:0]     alu_target;
    logic            ex_valid;
    logic            ex_ready;
    logic [31:0]     ex_result;
    logic [RD_W-1:0] ex_rd;
    logic            ex_wen;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            flush;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_stage_ctrl #(.RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_op1(id_op1), .id_op2(id_op2), .id_aluop(id_aluop),
        .id_branch(id_branch), .id_bne(id_bne), .id_jump(id_jump),
        .id_addr(id_addr), .id_rd(id_rd), .id_wen(id_wen),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc),
        .alu_addr(alu_addr), .alu_branch(alu_branch), .alu_jump(alu_jump),
        .alu_result(alu_result), .alu_target(alu_target),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_rd(ex_rd), .ex_wen(ex_wen),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
    );

    // Behavioural ALU; opcode 0 yields a nonzero value so result forcing is visible.
    always_comb begin
        case (alu_op)
            3'd1:    alu_result = alu_a + alu_b;
            3'd2:    alu_result = alu_a - alu_b;
            3'd3:    alu_result = alu_a & alu_b;
            3'd4:    alu_result = alu_a | alu_b;
            3'd5:    alu_result = {31'd0, alu_a < alu_b};
            3'd6:    alu_result = {31'd0, alu_a == alu_b};
            3'd7:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = alu_a ^ alu_b;
        endcase
        if (alu_jump) alu_target = {alu_pc[31:28], alu_addr, 2'b00};
        else          alu_target = alu_pc + {{4{alu_addr[25]}}, alu_addr, 2'b00};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op, input logic br,
                         input logic ne, input logic jp, input logic [25:0] ad,
                         input logic [RD_W-1:0] rd, input logic we);
        id_valid = v; id_pc = pc; id_op1 = a; id_op2 = b; id_aluop = op;
        id_branch = br; id_bne = ne; id_jump = jp; id_addr = ad; id_rd = rd; id_wen = we;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 26'd0, '0, 1'b0);
    endtask

    initial begin
        // 1. Reset with id_valid high
        rst_n = 1'b0; ex_ready = 1'b1;
        drive(1'b1, 32'h0, 32'd1, 32'd1, 3'd1, 1'b0, 1'b0, 1'b0, 26'd0, 5'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_id_ready", 32'(id_ready), 32'd0);
            check("rst_ex_valid", 32'(ex_valid), 32'd0);
            check("rst_ex_result", ex_result, 32'd0);
            check("rst_redirect", 32'({redirect_valid, flush}), 32'd0);
            check("rst_redirect_pc", redirect_pc, 32'd0);
            check("rst_alu_op", 32'(alu_op), 32'd0);
        end
        rst_n = 1'b1; idle(); #1;
        check("post_rst_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("post_rst_nothing_accepted", 32'({ex_valid, alu_op}), 32'd0);

        // 2. ADD then back-to-back SUB
        drive(1'b1, 32'h0, 32'd5, 32'd7, 3'd1, 1'b0, 1'b0, 1'b0, 26'd0, 5'd3, 1'b1);
        #1 check("add_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("add_alu_op", 32'(alu_op), 32'd1);
        check("add_ex_valid_early", 32'(ex_valid), 32'd0);
        drive(1'b1, 32'h0, 32'd7, 32'd5, 3'd2, 1'b0, 1'b0, 1'b0, 26'd0, 5'd4, 1'b1);
        #1 check("sub_id_ready", 32'(id_ready), 32'd1);
        tick();
        idle();
        check("add_ex_valid", 32'(ex_valid), 32'd1);
        check("add_result", ex_result, 32'd12);
        check("add_rd", 32'(ex_rd), 32'd3);
        tick();
        check("sub_result", ex_result, 32'd2);
        check("sub_rd_valid", 32'({ex_valid, ex_rd}), 32'h24);
        tick();
        check("drain_ex_valid", 32'(ex_valid), 32'd0);

        // 3. Backpressure: AND, OR, SLTU
        ex_ready = 1'b0;
        drive(1'b1, 32'h0, 32'hF0, 32'h3C, 3'd3, 1'b0, 1'b0, 1'b0, 26'd0, 5'd5, 1'b1);
        tick();
        drive(1'b1, 32'h0, 32'hF0, 32'h0F, 3'd4, 1'b0, 1'b0, 1'b0, 26'd0, 5'd6, 1'b1);
        #1 check("bp_or_id_ready", 32'(id_ready), 32'd1);
        tick();
        drive(1'b1, 32'h0, 32'd1, 32'd2, 3'd5, 1'b0, 1'b0, 1'b0, 26'd0, 5'd7, 1'b1);
        #1 check("bp_stall_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("bp_hold_result", ex_result, 32'h30);
        check("bp_hold_rd_valid", 32'({ex_valid, ex_rd}), 32'h25);
        check("bp_hold_id_ready", 32'(id_ready), 32'd0);
        ex_ready = 1'b1;
        #1 check("bp_release_id_ready", 32'(id_ready), 32'd1);
        tick();
        idle();
        check("bp_second_result", ex_result, 32'hFF);
        check("bp_second_rd", 32'(ex_rd), 32'd6);
        tick();
        check("bp_third_result", ex_result, 32'd1);
        check("bp_third_rd", 32'(ex_rd), 32'd7);
        tick();
        check("bp_drained", 32'(ex_valid), 32'd0);

        // 4. Taken BEQ with a filler instruction offered during the bubble
        drive(1'b1, 32'h100, 32'd9, 32'd9, 3'd6, 1'b1, 1'b0, 1'b0, 26'h4, 5'd0, 1'b0);
        tick();
        drive(1'b1, 32'h0, 32'd1, 32'd1, 3'd1, 1'b0, 1'b0, 1'b0, 26'd0, 5'd8, 1'b1);
        #1 check("beq_ex_id_ready", 32'(id_ready), 32'd0);
        check("beq_alu_branch", 32'(alu_branch), 32'd1);
        check("beq_no_early_redirect", 32'(redirect_valid), 32'd0);
        tick();
        check("beq_redirect_flush", 32'({redirect_valid, flush}), 32'd3);
        check("beq_redirect_pc", redirect_pc, 32'h110);
        check("beq_redir_id_ready", 32'(id_ready), 32'd0);
        check("beq_ex_valid", 32'(ex_valid), 32'd0);
        idle();
        tick();
        check("beq_pulse_end", 32'({redirect_valid, flush}), 32'd0);
        check("beq_after_id_ready", 32'(id_ready), 32'd1);
        check("beq_filler_dropped", 32'(ex_valid), 32'd0);

        // 5. Not-taken BEQ (9 vs 8) and BNE (9 vs 9)
        drive(1'b1, 32'h200, 32'd9, 32'd8, 3'd6, 1'b1, 1'b0, 1'b0, 26'h4, 5'd0, 1'b0);
        tick();
        idle();
        #1 check("beq_nt_ex_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("beq_nt_redirect", 32'(redirect_valid), 32'd0);
        check("beq_nt_id_ready", 32'(id_ready), 32'd1);
        drive(1'b1, 32'h300, 32'd9, 32'd9, 3'd6, 1'b1, 1'b1, 1'b0, 26'h4, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        check("bne_nt_redirect", 32'({redirect_valid, flush}), 32'd0);
        check("bne_nt_id_ready", 32'(id_ready), 32'd1);

        // Branch and jump both set: branch sense decides (1 != 2, so not taken)
        drive(1'b1, 32'h400, 32'd1, 32'd2, 3'd6, 1'b1, 1'b0, 1'b1, 26'h40, 5'd0, 1'b0);
        tick();
        idle();
        check("prio_alu_jump", 32'({alu_branch, alu_jump}), 32'd2);
        tick();
        check("prio_no_redirect", 32'(redirect_valid), 32'd0);

        // Illegal opcode 0 on an ALU instruction
        drive(1'b1, 32'h0, 32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 1'b0, 26'd0, 5'd9, 1'b1);
        tick();
        idle();
        tick();
        check("illegal_result", ex_result, 32'd0);
        check("illegal_wen_rd", 32'({ex_valid, ex_wen, ex_rd}), 32'({1'b1, 1'b1, 5'd9}));
        tick();

        // 6. Jump, then jump cancelled by reset in its EX cycle
        drive(1'b1, 32'hA000_0000, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 26'h40, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        check("jump_redirect", 32'({redirect_valid, flush}), 32'd3);
        check("jump_redirect_pc", redirect_pc, 32'hA000_0100);
        tick();
        drive(1'b1, 32'hA000_0000, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 26'h40, 5'd0, 1'b0);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        check("jump_rst_no_redirect", 32'({redirect_valid, flush}), 32'd0);
        check("jump_rst_id_ready", 32'(id_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("jump_rst_empty", 32'(id_ready), 32'd1);
        tick();
        check("jump_rst_no_late_pulse", 32'({redirect_valid, flush, ex_valid}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
